// File: rtl/multi_8bit_pkg.sv
// multi_8bit_pkg: shared types and default widths for the shift-and-add multiplier
//   W_MCAND  multiplicand / product width
//   W_MPLIER multiplier width and iteration count
//   CNT_W    width of the iteration counter
//   state_t  controller states
package multi_8bit_pkg;
    localparam int W_MCAND = 16;
    localparam int W_MPLIER = 8;
    localparam int CNT_W = $clog2(W_MPLIER + 1);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/multi_8bit_if.sv
// multi_8bit_if: start/operand/result bundle of the multiplier
//   inicio        start request (master -> slave)
//   multiplicando unsigned multiplicand (master -> slave)
//   multiplicador unsigned multiplier (master -> slave)
//   produto       truncated product (slave -> master)
//   fim           sticky done flag (slave -> master)
interface multi_8bit_if
    import multi_8bit_pkg::*;
#(
    parameter int MCAND_W = W_MCAND,
    parameter int MPLIER_W = W_MPLIER
);
    logic inicio;
    logic [MCAND_W-1:0] multiplicando;
    logic [MPLIER_W-1:0] multiplicador;
    logic [MCAND_W-1:0] produto;
    logic fim;
    modport master(output inicio, multiplicando, multiplicador, input produto, fim);
    modport slave(input inicio, multiplicando, multiplicador, output produto, fim);
endinterface

// File: rtl/multi_8bit_dp.sv
// multi_8bit_dp: accumulator, shifting operand registers and iteration counter
//   clk, rst     clock, asynchronous active-high reset
//   load_i       latch operands, clear acc and counter
//   step_i       perform one shift-and-add iteration
//   mcand_i      multiplicand to latch
//   mplier_i     multiplier to latch
//   acc_next_o   accumulator value after the current edge
//   last_iter_o  the current step is the final iteration
module multi_8bit_dp
    import multi_8bit_pkg::*;
#(
    parameter int MCAND_W = W_MCAND,
    parameter int MPLIER_W = W_MPLIER
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic                step_i,
    input  logic [MCAND_W-1:0]  mcand_i,
    input  logic [MPLIER_W-1:0] mplier_i,
    output logic [MCAND_W-1:0]  acc_next_o,
    output logic                last_iter_o
);
    localparam int CW = $clog2(MPLIER_W + 1);
    logic [MCAND_W-1:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [MPLIER_W-1:0] mplier_q, mplier_d;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        acc_d = load_i ? '0 : (step_i && mplier_q[0]) ? acc_q + mcand_q : acc_q;
        mcand_d = load_i ? mcand_i : step_i ? mcand_q << 1 : mcand_q;
        mplier_d = load_i ? mplier_i : step_i ? mplier_q >> 1 : mplier_q;
        cnt_d = load_i ? '0 : step_i ? cnt_q + CW'(1) : cnt_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            mcand_q <= '0;
            mplier_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            mcand_q <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q <= cnt_d;
        end
    end
    // The final sum is forwarded combinationally so the product register
    // captures it on the same edge as the last iteration.
    assign acc_next_o = acc_d;
    assign last_iter_o = cnt_q == CW'(MPLIER_W - 1);
endmodule

// File: rtl/multi_8bit.sv
// multi_8bit: sequential shift-and-add multiplier, one multiplier bit per clock
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  slave side of multi_8bit_if (inicio/operands in, produto/fim out)
module multi_8bit
    import multi_8bit_pkg::*;
#(
    parameter int MCAND_W = W_MCAND,
    parameter int MPLIER_W = W_MPLIER
) (
    input logic          clk,
    input logic          rst,
    multi_8bit_if.slave  bus
);
    state_t state_q, state_d;
    logic [MCAND_W-1:0] produto_q, produto_d, acc_next;
    logic fim_q, fim_d, load, step, last_iter, finish;
    multi_8bit_dp #(.MCAND_W(MCAND_W), .MPLIER_W(MPLIER_W)) u_dp (
        .clk(clk),
        .rst(rst),
        .load_i(load),
        .step_i(step),
        .mcand_i(bus.multiplicando),
        .mplier_i(bus.multiplicador),
        .acc_next_o(acc_next),
        .last_iter_o(last_iter)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            produto_q <= '0;
            fim_q <= 1'b0;
        end else begin
            state_q <= state_d;
            produto_q <= produto_d;
            fim_q <= fim_d;
        end
    end
    always_comb begin
        state_d = state_q == CALC ? (last_iter ? DONE : CALC) : (bus.inicio ? CALC : state_q);
    end
    always_comb begin
        load = state_q != CALC && bus.inicio;
        step = state_q == CALC;
        finish = step && last_iter;
        fim_d = load ? 1'b0 : finish ? 1'b1 : fim_q;
        produto_d = finish ? acc_next : produto_q;
    end
    assign bus.produto = produto_q;
    assign bus.fim = fim_q;
endmodule

// File: tb/tb_multi_8bit.sv
// tb_multi_8bit: directed scoreboard bench for multi_8bit
module tb_multi_8bit;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    int unsigned q[$];
    int unsigned ops[4][2] = '{'{0, 255}, '{65535, 1}, '{65535, 255}, '{300, 255}};

    always #5 clk = ~clk;

    multi_8bit_if #(.MCAND_W(16), .MPLIER_W(8)) bus ();
    multi_8bit dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic start(input int unsigned a, input int unsigned b);
        @(negedge clk);
        bus.multiplicando = 16'(a);
        bus.multiplicador = 8'(b);
        bus.inicio = 1'b1;
        q.push_back((a * b) % 65536);
        @(negedge clk);
        bus.inicio = 1'b0;
        chk("fim_drop", 32'(bus.fim), 0);
    endtask

    task automatic finish(input bit noise);
        int n = 99;
        int unsigned e;
        for (int k = 2; k <= 20 && n == 99; k++) begin
            if (noise && k <= 6) begin
                bus.multiplicando = 16'($urandom);
                bus.multiplicador = 8'($urandom);
                bus.inicio = (k == 3);
            end
            @(negedge clk);
            if (bus.fim === 1'b1) n = k;
        end
        chk("latency", n, 9);
        e = q.pop_front();
        chk("produto", 32'(bus.produto), e);
    endtask

    initial begin
        rst = 1'b1;
        bus.inicio = 1'b0;
        bus.multiplicando = '0;
        bus.multiplicador = '0;
        repeat (2) @(negedge clk);
        chk("rst_prod", 32'(bus.produto), 0);
        chk("rst_fim", 32'(bus.fim), 0);
        rst = 1'b0;
        start(25, 12);
        finish(1'b0);
        repeat (100) @(negedge clk);
        chk("hold_fim", 32'(bus.fim), 1);
        chk("hold_prod", 32'(bus.produto), 300);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_prod", 32'(bus.produto), 0);
        chk("async_fim", 32'(bus.fim), 0);
        repeat (3) @(negedge clk);
        chk("rst_hold_fim", 32'(bus.fim), 0);
        rst = 1'b0;
        start(10, 12);
        finish(1'b0);
        @(negedge clk);
        bus.multiplicando = 16'd50;
        bus.multiplicador = 8'd50;
        bus.inicio = 1'b1;
        @(negedge clk);
        bus.inicio = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_prod", 32'(bus.produto), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_fim", 32'(bus.fim), 0);
        chk("abort_prod2", 32'(bus.produto), 0);
        for (int i = 0; i < 4; i++) begin
            start(ops[i][0], ops[i][1]);
            finish(1'b0);
        end
        start(7, 3);
        finish(1'b0);
        start(9, 9);
        finish(1'b0);
        start(100, 5);
        finish(1'b1);
        repeat (3) @(negedge clk);
        chk("noise_hold", 32'(bus.produto), 500);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
